radix4_pp_accumulator: RTL

- Downstream stage of the radix-4 partial-product generator.
- Consumes one signed PP_W-bit partial product per radix-4 digit, least-significant digit first.
- Aligns each partial product by 2 bits per digit, sign-extends it, and accumulates it into an OUT_W-bit product.
- Presents the finished product through a valid/ready handshake and sequences the digit index back to the upstream stage.

---
 rtl/radix4_pp_accumulator.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/radix4_pp_accumulator.sv
// radix4_pp_accumulator
//
// Downstream stage of a radix-4 multiplier. It takes one signed partial
// product per radix-4 digit, least-significant digit first. Each partial
// product is sign-extended to the product width, shifted left by two bits
// per digit position, and added into a wrap-around accumulator. The
// finished product is held on a valid/ready interface until the consumer
// takes it.
//
// Ports:
//   clk_i        clock; all state changes on the rising edge
//   rst_i        synchronous active-high reset; aborts any operation
//   start_i      begin a new multiplication (pulse or level)
//   busy_o       high whenever the block is not idle
//   digit_idx_o  index of the digit whose partial product is expected next
//   pp_valid_i   partial product on pp_i is valid
//   pp_ready_o   block accepts pp_i this cycle
//   pp_i         signed (two's complement) partial product
//   res_valid_o  product on res_o is valid
//   res_ready_i  consumer accepts res_o
//   res_o        signed product, modulo 2^OUT_W
//
// Every output is either a register or a decode of the state register, so
// there is no combinational path from any input to any output.
module radix4_pp_accumulator #(
  parameter int PP_W    = 10,
  parameter int NUM_DIG = 4,
  parameter int OUT_W   = 16   // must equal PP_W + 2*(NUM_DIG-1)
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       start_i,
  output logic                       busy_o,
  output logic [$clog2(NUM_DIG)-1:0] digit_idx_o,
  input  logic                       pp_valid_i,
  output logic                       pp_ready_o,
  input  logic [PP_W-1:0]            pp_i,
  output logic                       res_valid_o,
  input  logic                       res_ready_i,
  output logic [OUT_W-1:0]           res_o
);

  localparam int IDX_W = $clog2(NUM_DIG);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIG - 1);

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    HOLD
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [OUT_W-1:0]  acc;
  logic [IDX_W-1:0]  cnt;
  logic [OUT_W-1:0]  res;

  logic              transfer;
  logic              last_digit;
  logic [OUT_W-1:0]  pp_ext;
  logic [IDX_W:0]    shift_amt;
  logic [OUT_W-1:0]  sum;

  // Handshake and alignment. Each digit is worth a factor of 4, so the
  // sign-extended partial product moves left by 2*cnt bits. The addition
  // deliberately wraps at OUT_W bits.
  always_comb begin
    transfer   = pp_valid_i && (state == ACCUM);
    last_digit = (cnt == LAST_IDX);
    pp_ext     = {{(OUT_W - PP_W){pp_i[PP_W-1]}}, pp_i};
    shift_amt  = {cnt, 1'b0};
    sum        = acc + (pp_ext << shift_amt);
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. A start in ACCUM is ignored, and a start in HOLD only
  // counts when it arrives together with the result handshake.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start_i) begin
          state_next = ACCUM;
        end
      end
      ACCUM: begin
        if (transfer && last_digit) begin
          state_next = HOLD;
        end
      end
      HOLD: begin
        if (res_ready_i) begin
          state_next = start_i ? ACCUM : IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: accumulator, digit counter and result register. The result
  // register is loaded only when the last digit completes, so it stays
  // stable during HOLD and keeps its value after the handshake.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc <= '0;
      cnt <= '0;
      res <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_i) begin
            acc <= '0;
            cnt <= '0;
          end
        end
        ACCUM: begin
          if (transfer) begin
            acc <= sum;
            if (last_digit) begin
              res <= sum;
              cnt <= '0;
            end else begin
              cnt <= cnt + IDX_W'(1);
            end
          end
        end
        HOLD: begin
          if (res_ready_i && start_i) begin
            acc <= '0;
            cnt <= '0;
          end
        end
        default: begin
          acc <= '0;
          cnt <= '0;
        end
      endcase
    end
  end

  // Output decode from state and registered values only.
  always_comb begin
    busy_o      = (state != IDLE);
    pp_ready_o  = (state == ACCUM);
    res_valid_o = (state == HOLD);
    digit_idx_o = (state == ACCUM) ? cnt : '0;
    res_o       = res;
  end

endmodule
